// File: rtl/racetrack_defines.sv
// Shared definitions for the racetrack request controller: logic-in-memory
// function codes and the controller state encoding.
package racetrack_defines;

  localparam int unsigned FUNCT_WIDTH = 8;

  localparam logic [FUNCT_WIDTH-1:0] FUNCT_NONE = 8'h00;
  localparam logic [FUNCT_WIDTH-1:0] FUNCT_AND  = 8'h01;
  localparam logic [FUNCT_WIDTH-1:0] FUNCT_OR   = 8'h02;
  localparam logic [FUNCT_WIDTH-1:0] FUNCT_XOR  = 8'h03;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWaitValid,
    StResp
  } req_state_e;

endpackage

// File: rtl/racetrack_req_ctrl_if.sv
// Core-side request/response bus plus racetrack bank command bus.
// slave is the controller's view, master is the core/bank side.
interface racetrack_req_ctrl_if #(
  parameter int unsigned N_WIDTH    = 22,
  parameter int unsigned DATA_WIDTH = 32
);

  // Core side
  logic                  data_req_i;
  logic                  data_gnt_o;
  logic [N_WIDTH-1:0]    data_addr_i;
  logic                  data_we_i;
  logic [3:0]            data_be_i;
  logic [DATA_WIDTH-1:0] data_wdata_i;
  logic [7:0]            data_funct_i;
  logic                  data_rvalid_o;
  logic [DATA_WIDTH-1:0] data_rdata_o;
  logic                  data_err_o;

  // Bank side
  logic                  rt_en_o;
  logic                  rt_w_en_o;
  logic [N_WIDTH-1:0]    rt_addr_o;
  logic [3:0]            rt_be_o;
  logic [DATA_WIDTH-1:0] rt_wdata_o;
  logic [7:0]            rt_funct_o;
  logic                  rt_r_valid_i;
  logic [DATA_WIDTH-1:0] rt_rdata_i;

  modport slave (
    input  data_req_i, data_addr_i, data_we_i, data_be_i, data_wdata_i, data_funct_i,
    output data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
    output rt_en_o, rt_w_en_o, rt_addr_o, rt_be_o, rt_wdata_o, rt_funct_o,
    input  rt_r_valid_i, rt_rdata_i
  );

  modport master (
    output data_req_i, data_addr_i, data_we_i, data_be_i, data_wdata_i, data_funct_i,
    input  data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
    input  rt_en_o, rt_w_en_o, rt_addr_o, rt_be_o, rt_wdata_o, rt_funct_o,
    output rt_r_valid_i, rt_rdata_i
  );

endinterface

// File: rtl/racetrack_timeout_cnt.sv
// Loadable down-counter that saturates at zero; flags when it has expired.
module racetrack_timeout_cnt #(
  parameter int unsigned CNT_WIDTH = 10
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 load,
  input  logic [CNT_WIDTH-1:0] load_value,
  input  logic                 dec,
  output logic                 zero
);

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  // Load has priority; decrement stops at zero
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_value;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_WIDTH'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/racetrack_req_ctrl.sv
// Single-outstanding request controller between a core data port and a
// racetrack memory bank, with a per-request completion timeout.
module racetrack_req_ctrl
  import racetrack_defines::*;
#(
  parameter int unsigned N_WIDTH        = 22,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned CNT_WIDTH      = 10,
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input logic                  clk_i,
  input logic                  rstn_i,
  racetrack_req_ctrl_if.slave  bus
);

  if (64'(TIMEOUT_CYCLES) >= (64'd1 << CNT_WIDTH)) begin : g_timeout_too_wide
    $error("TIMEOUT_CYCLES does not fit in CNT_WIDTH bits");
  end

  req_state_e state_q, state_d;

  logic [N_WIDTH-1:0]    req_addr_q;
  logic                  req_we_q;
  logic [3:0]            req_be_q;
  logic [DATA_WIDTH-1:0] req_wdata_q;
  logic [7:0]            req_funct_q;

  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;

  logic grant;
  logic cnt_load;
  logic cnt_dec;
  logic cnt_zero;
  logic bank_active;

  racetrack_timeout_cnt #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_timeout_cnt (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .load       (cnt_load),
    .load_value (CNT_WIDTH'(TIMEOUT_CYCLES)),
    .dec        (cnt_dec),
    .zero       (cnt_zero)
  );

  // Next-state, grant and response capture
  always_comb begin
    state_d  = state_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    grant    = 1'b0;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    unique case (state_q)
      StIdle, StResp: begin
        // Gated by reset so the grant output is quiet while held in reset
        if (bus.data_req_i && rstn_i) begin
          grant    = 1'b1;
          cnt_load = 1'b1;
          state_d  = StIssue;
        end else begin
          state_d = StIdle;
        end
      end
      StIssue: begin
        state_d = StWaitValid;
      end
      StWaitValid: begin
        cnt_dec = 1'b1;
        // Bank valid takes priority over an expiring counter
        if (bus.rt_r_valid_i) begin
          rdata_d = bus.rt_rdata_i;
          err_d   = 1'b0;
          state_d = StResp;
        end else if (cnt_zero) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = StResp;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State, request register and response register
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= StIdle;
      req_addr_q  <= '0;
      req_we_q    <= 1'b0;
      req_be_q    <= '0;
      req_wdata_q <= '0;
      req_funct_q <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (grant) begin
        req_addr_q  <= bus.data_addr_i;
        req_we_q    <= bus.data_we_i;
        req_be_q    <= bus.data_be_i;
        req_wdata_q <= bus.data_wdata_i;
        req_funct_q <= bus.data_funct_i;
      end
    end
  end

  // Output decode; bank command fields only visible while a command is live
  always_comb begin
    bank_active       = (state_q == StIssue) || (state_q == StWaitValid);
    bus.data_gnt_o    = grant;
    bus.data_rvalid_o = (state_q == StResp);
    bus.data_err_o    = (state_q == StResp) && err_q;
    bus.data_rdata_o  = rdata_q;
    bus.rt_en_o       = (state_q == StIssue);
    bus.rt_w_en_o     = bank_active && req_we_q;
    bus.rt_addr_o     = bank_active ? req_addr_q  : '0;
    bus.rt_be_o       = bank_active ? req_be_q    : '0;
    bus.rt_wdata_o    = bank_active ? req_wdata_q : '0;
    bus.rt_funct_o    = bank_active ? req_funct_q : '0;
  end

endmodule

// File: tb/tb_racetrack_req_ctrl.sv
// Self-checking bench for racetrack_req_ctrl: expected responses are queued
// when a request is granted and matched when data_rvalid_o pulses.
module tb_racetrack_req_ctrl;
  import racetrack_defines::*;

  localparam int unsigned NW = 22;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 10;
  localparam int unsigned TO = 8;

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
    int unsigned   cyc;
  } rsp_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  racetrack_req_ctrl_if #(.N_WIDTH(NW), .DATA_WIDTH(DW)) bus ();

  racetrack_req_ctrl #(
    .N_WIDTH        (NW),
    .DATA_WIDTH     (DW),
    .CNT_WIDTH      (CW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk_i  (clk),
    .rstn_i (rstn),
    .bus    (bus)
  );

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   n_vec = 0;
  int   n_bad = 0;
  rsp_t sb[$];
  rsp_t exp_rsp;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic [NW-1:0] a, input logic we, input logic [3:0] be,
                           input logic [DW-1:0] wd, input logic [7:0] f);
    bus.data_req_i   = 1'b1;
    bus.data_addr_i  = a;
    bus.data_we_i    = we;
    bus.data_be_i    = be;
    bus.data_wdata_i = wd;
    bus.data_funct_i = f;
    #1;
  endtask

  task automatic idle_req();
    bus.data_req_i   = 1'b0;
    bus.data_addr_i  = '0;
    bus.data_we_i    = 1'b0;
    bus.data_be_i    = '0;
    bus.data_wdata_i = '0;
    bus.data_funct_i = FUNCT_NONE;
  endtask

  task automatic push(input logic [DW-1:0] rdata, input logic err, input int unsigned lat);
    rsp_t e;
    e.rdata = rdata;
    e.err   = err;
    e.cyc   = cyc + lat;
    sb.push_back(e);
  endtask

  task automatic bank_valid(input logic v, input logic [DW-1:0] d);
    bus.rt_r_valid_i = v;
    bus.rt_rdata_i   = d;
  endtask

  // Scoreboard: every response pulse must match the oldest queued expectation
  always @(negedge clk) begin
    if (bus.data_rvalid_o === 1'b1) begin
      if (sb.size() == 0) begin
        check("stray_rvalid", 64'd1, 64'd0);
      end else begin
        exp_rsp = sb.pop_front();
        check("rsp_rdata", 64'(bus.data_rdata_o), 64'(exp_rsp.rdata));
        check("rsp_err", 64'(bus.data_err_o), 64'(exp_rsp.err));
        check("rsp_cycle", 64'(cyc), 64'(exp_rsp.cyc));
      end
    end
  end

  initial begin
    idle_req();
    bank_valid(1'b0, '0);
    bus.data_req_i = 1'b1;
    rstn = 1'b0;
    tick();
    tick();

    // Reset state with a request pending
    check("rst_gnt", 64'(bus.data_gnt_o), 64'd0);
    check("rst_rvalid", 64'(bus.data_rvalid_o), 64'd0);
    check("rst_err", 64'(bus.data_err_o), 64'd0);
    check("rst_rdata", 64'(bus.data_rdata_o), 64'd0);
    check("rst_rt_en", 64'(bus.rt_en_o), 64'd0);
    check("rst_rt_addr", 64'(bus.rt_addr_o), 64'd0);
    idle_req();
    rstn = 1'b1;
    tick();

    // Read: rt_en at cycle 1, bank valid at 6, response at 7
    drive_req(22'h00010, 1'b0, 4'b1111, '0, FUNCT_NONE);
    check("rd_gnt", 64'(bus.data_gnt_o), 64'd1);
    push(32'hDEADBEEF, 1'b0, 7);
    tick();
    idle_req();
    check("rd_rt_en", 64'(bus.rt_en_o), 64'd1);
    check("rd_rt_addr", 64'(bus.rt_addr_o), 64'h10);
    check("rd_rt_we", 64'(bus.rt_w_en_o), 64'd0);
    check("rd_gnt_issue", 64'(bus.data_gnt_o), 64'd0);
    tick();
    check("rd_rt_en_one", 64'(bus.rt_en_o), 64'd0);
    check("rd_addr_hold", 64'(bus.rt_addr_o), 64'h10);
    repeat (4) tick();
    bank_valid(1'b1, 32'hDEADBEEF);
    tick();
    bank_valid(1'b0, '0);
    tick();

    // Write with logic-in-memory AND: command fields stable while waiting
    drive_req(22'h3FFFFF, 1'b1, 4'b0011, 32'h12345678, FUNCT_AND);
    check("wr_gnt", 64'(bus.data_gnt_o), 64'd1);
    push(32'h00004560, 1'b0, 5);
    tick();
    idle_req();
    for (int i = 1; i <= 4; i++) begin
      check("wr_rt_en", 64'(bus.rt_en_o), (i == 1) ? 64'd1 : 64'd0);
      check("wr_rt_we", 64'(bus.rt_w_en_o), 64'd1);
      check("wr_rt_be", 64'(bus.rt_be_o), 64'b0011);
      check("wr_rt_funct", 64'(bus.rt_funct_o), 64'(FUNCT_AND));
      check("wr_rt_wdata", 64'(bus.rt_wdata_o), 64'h12345678);
      check("wr_rt_addr", 64'(bus.rt_addr_o), 64'h3FFFFF);
      if (i < 4) tick();
    end
    bank_valid(1'b1, 32'h00004560);
    tick();
    bank_valid(1'b0, '0);
    tick();

    // Timeout: counter is 8 in ISSUE, reaches 0 at cycle 10, error response at 11
    drive_req(22'h00055, 1'b0, 4'b1111, '0, FUNCT_NONE);
    push('0, 1'b1, 11);
    tick();
    idle_req();
    repeat (10) tick();
    tick();
    bank_valid(1'b1, 32'h11111111);
    tick();
    bank_valid(1'b0, '0);
    check("late_valid_rvalid", 64'(bus.data_rvalid_o), 64'd0);
    check("late_valid_rdata", 64'(bus.data_rdata_o), 64'd0);
    tick();

    // Race: bank valid in the cycle the counter is 0
    drive_req(22'h00066, 1'b0, 4'b1111, '0, FUNCT_NONE);
    push(32'hCAFEF00D, 1'b0, 11);
    tick();
    idle_req();
    repeat (9) tick();
    bank_valid(1'b1, 32'hCAFEF00D);
    tick();
    bank_valid(1'b0, '0);
    tick();

    // Back-to-back: req held; second grant lands in RESP
    drive_req(22'h00100, 1'b0, 4'b1111, '0, FUNCT_NONE);
    push(32'hA1A1A1A1, 1'b0, 4);
    tick();
    check("b2b_gnt_issue", 64'(bus.data_gnt_o), 64'd0);
    drive_req(22'h00200, 1'b0, 4'b1111, '0, FUNCT_NONE);
    check("b2b_addr_latched", 64'(bus.rt_addr_o), 64'h100);
    tick();
    tick();
    bank_valid(1'b1, 32'hA1A1A1A1);
    tick();
    bank_valid(1'b0, '0);
    check("b2b_gnt_resp", 64'(bus.data_gnt_o), 64'd1);
    push(32'hB2B2B2B2, 1'b0, 4);
    tick();
    idle_req();
    check("b2b_rt_en", 64'(bus.rt_en_o), 64'd1);
    check("b2b_rt_addr", 64'(bus.rt_addr_o), 64'h200);
    tick();
    tick();
    bank_valid(1'b1, 32'hB2B2B2B2);
    tick();
    bank_valid(1'b0, '0);
    tick();

    // Reset while waiting: everything drops at once, no response afterwards
    drive_req(22'h00077, 1'b1, 4'b1100, 32'h0F0F0F0F, FUNCT_XOR);
    check("rst_op_gnt", 64'(bus.data_gnt_o), 64'd1);
    tick();
    idle_req();
    tick();
    tick();
    rstn = 1'b0;
    bus.data_req_i = 1'b1;
    #1;
    check("midrst_rt_en", 64'(bus.rt_en_o), 64'd0);
    check("midrst_rt_we", 64'(bus.rt_w_en_o), 64'd0);
    check("midrst_rt_addr", 64'(bus.rt_addr_o), 64'd0);
    check("midrst_rt_be", 64'(bus.rt_be_o), 64'd0);
    check("midrst_rt_wdata", 64'(bus.rt_wdata_o), 64'd0);
    check("midrst_rt_funct", 64'(bus.rt_funct_o), 64'd0);
    check("midrst_gnt", 64'(bus.data_gnt_o), 64'd0);
    check("midrst_rvalid", 64'(bus.data_rvalid_o), 64'd0);
    check("midrst_rdata", 64'(bus.data_rdata_o), 64'd0);
    tick();
    tick();
    idle_req();
    bank_valid(1'b1, 32'h99999999);
    rstn = 1'b1;
    tick();
    bank_valid(1'b0, '0);
    tick();
    check("post_rst_rvalid", 64'(bus.data_rvalid_o), 64'd0);

    // First request after reset behaves as from IDLE
    drive_req(22'h00088, 1'b0, 4'b1111, '0, FUNCT_NONE);
    check("post_rst_gnt", 64'(bus.data_gnt_o), 64'd1);
    push(32'h0BADF00D, 1'b0, 3);
    tick();
    idle_req();
    check("post_rst_rt_en", 64'(bus.rt_en_o), 64'd1);
    tick();
    bank_valid(1'b1, 32'h0BADF00D);
    tick();
    bank_valid(1'b0, '0);
    tick();
    tick();

    check("sb_drain", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
